// File: rtl/lifo_stack.sv
// lifo_stack: parametrised register-array LIFO with strobe/ack push and pop.
// Define LIFO_STACK_ERR_EN to build the sticky OVF/UNF error flags.
module lifo_stack #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLR,
  input  logic             PUSH_STB,
  input  logic [WIDTH-1:0] PUSH_DAT,
  output logic             PUSH_ACK,
  input  logic             POP_STB,
  output logic [WIDTH-1:0] POP_DAT,
  output logic             POP_ACK,
  output logic             FULL,
  output logic             EMPTY,
  output logic [CNT_W-1:0] LEVEL,
  output logic             OVF,
  output logic             UNF
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] LP_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CNT_W-1:0] r_sp;
  logic             r_push_ack;
  logic             r_pop_ack;
  logic [WIDTH-1:0] r_pop_dat;

  logic             w_full;
  logic             w_empty;
  logic             w_push_ok;
  logic             w_pop_ok;
  logic [CNT_W-1:0] w_top;
  logic [IDX_W-1:0] w_rd_idx;
  logic [IDX_W-1:0] w_wr_idx;

  assign w_full    = (r_sp == LP_FULL);
  assign w_empty   = (r_sp == '0);
  assign w_pop_ok  = POP_STB & ~CLR & ~w_empty;
  // a pop in the same cycle frees the top slot, so push is fine even when full
  assign w_push_ok = PUSH_STB & ~CLR & (~w_full | w_pop_ok);
  assign w_top     = r_sp - CNT_W'(1);
  assign w_rd_idx  = w_top[IDX_W-1:0];
  assign w_wr_idx  = w_pop_ok ? w_rd_idx : r_sp[IDX_W-1:0];

  always_ff @(posedge CLK) begin
    if (w_push_ok) r_mem[w_wr_idx] <= PUSH_DAT;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_sp       <= '0;
      r_push_ack <= 1'b0;
      r_pop_ack  <= 1'b0;
      r_pop_dat  <= '0;
    end else begin
      r_push_ack <= w_push_ok;
      r_pop_ack  <= w_pop_ok;
      if (w_pop_ok) r_pop_dat <= r_mem[w_rd_idx];
      if (CLR) r_sp <= '0;
      else if (w_push_ok & ~w_pop_ok) r_sp <= r_sp + CNT_W'(1);
      else if (w_pop_ok & ~w_push_ok) r_sp <= w_top;
    end
  end

`ifdef LIFO_STACK_ERR_EN
  logic r_ovf;
  logic r_unf;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (CLR) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (PUSH_STB & ~POP_STB & w_full) r_ovf <= 1'b1;
      if (POP_STB & w_empty) r_unf <= 1'b1;
    end
  end

  assign OVF = r_ovf;
  assign UNF = r_unf;
`else
  assign OVF = 1'b0;
  assign UNF = 1'b0;
`endif

  assign PUSH_ACK = r_push_ack;
  assign POP_ACK  = r_pop_ack;
  assign POP_DAT  = r_pop_dat;
  assign FULL     = w_full;
  assign EMPTY    = w_empty;
  assign LEVEL    = r_sp;

endmodule

// File: tb/tb_lifo_stack.sv
// tb_lifo_stack: directed and randomized checks of lifo_stack
// against a queue-based reference model.
module tb_lifo_stack;
  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int CNT_W = 5;
  localparam int VW = WIDTH + CNT_W + 6;
`ifdef LIFO_STACK_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic             CLR = 1'b0;
  logic             PUSH_STB = 1'b0;
  logic [WIDTH-1:0] PUSH_DAT = '0;
  logic             POP_STB = 1'b0;
  logic             PUSH_ACK;
  logic [WIDTH-1:0] POP_DAT;
  logic             POP_ACK;
  logic             FULL;
  logic             EMPTY;
  logic [CNT_W-1:0] LEVEL;
  logic             OVF;
  logic             UNF;

  lifo_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .CLR(CLR),
    .PUSH_STB(PUSH_STB), .PUSH_DAT(PUSH_DAT), .PUSH_ACK(PUSH_ACK),
    .POP_STB(POP_STB), .POP_DAT(POP_DAT), .POP_ACK(POP_ACK),
    .FULL(FULL), .EMPTY(EMPTY), .LEVEL(LEVEL), .OVF(OVF), .UNF(UNF)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_pass = 0;

  logic [WIDTH-1:0] q[$];
  bit               m_pa = 0;
  bit               m_po = 0;
  bit               m_ovf = 0;
  bit               m_unf = 0;
  logic [WIDTH-1:0] m_pd = '0;

  wire [VW-1:0] w_act = {PUSH_ACK, POP_ACK, POP_DAT, FULL, EMPTY,
                         LEVEL, OVF, UNF};

  function automatic logic [VW-1:0] model_vec();
    logic f, e;
    f = (q.size() == DEPTH);
    e = (q.size() == 0);
    return {m_pa, m_po, m_pd, f, e, CNT_W'(q.size()),
            m_ovf & ERR_EN, m_unf & ERR_EN};
  endfunction

  task automatic model_reset();
    q.delete();
    m_pa = 0; m_po = 0; m_ovf = 0; m_unf = 0; m_pd = '0;
  endtask

  // drive one cycle of requests and advance the model; called at posedge+1
  task automatic step(input bit clr, input bit ps,
                      input logic [WIDTH-1:0] d, input bit pp);
    bit full, empty;
    CLR = clr; PUSH_STB = ps; PUSH_DAT = d; POP_STB = pp;
    @(posedge CLK);
    full = (q.size() == DEPTH);
    empty = (q.size() == 0);
    m_pa = 0; m_po = 0;
    if (clr) begin
      q.delete(); m_ovf = 0; m_unf = 0;
    end else if (ps && pp && !empty) begin
      m_pd = q[q.size()-1];
      q[q.size()-1] = d;
      m_pa = 1; m_po = 1;
    end else begin
      if (ps) begin
        if (!full) begin q.push_back(d); m_pa = 1; end
        else m_ovf = 1;
      end
      if (pp) begin
        if (!empty) begin m_pd = q.pop_back(); m_po = 1; end
        else m_unf = 1;
      end
    end
    #1;
    CLR = 0; PUSH_STB = 0; POP_STB = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge CLK);
    #1;
    model_reset();
    n_chk++;
    if (w_act !== model_vec())
      $display("FAIL por_state act=%h exp=%h", w_act, model_vec());
    else n_pass++;
    RST = 1'b1;
    step(0, 0, 0, 0);
    n_chk++;
    if (PUSH_ACK !== 1'b0 || POP_ACK !== 1'b0 || EMPTY !== 1'b1)
      $display("FAIL por_release act=%b%b%b exp=001",
               PUSH_ACK, POP_ACK, EMPTY);
    else n_pass++;
    // async reset in the middle of a push burst
    PUSH_STB = 1'b1; PUSH_DAT = 32'h7;
    @(posedge CLK);
    @(posedge CLK);
    #3 RST = 1'b0;
    #400;
    model_reset();
    n_chk++;
    if (w_act !== model_vec() || LEVEL !== 0 || EMPTY !== 1'b1)
      $display("FAIL mid_reset act=%h exp=%h", w_act, model_vec());
    else n_pass++;
    PUSH_STB = 1'b0;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    n_chk++;
    if (w_act !== model_vec())
      $display("FAIL reset_release act=%h exp=%h", w_act, model_vec());
    else n_pass++;
  endtask

  task automatic test_fill();
    int acks = 0;
    for (int i = 17; i <= 31; i++) begin
      step(0, 1, i, 0);
      if (PUSH_ACK === 1'b1) acks++;
      n_chk++;
      if (w_act !== model_vec())
        $display("FAIL fill[%0d] act=%h exp=%h", i, w_act, model_vec());
      else n_pass++;
    end
    n_chk++;
    if (acks != 15 || LEVEL !== 15 || FULL !== 1'b0)
      $display("FAIL fill15 acks=%0d level=%0d full=%b exp=15/15/0",
               acks, LEVEL, FULL);
    else n_pass++;
    step(0, 1, 32, 0);
    n_chk++;
    if (LEVEL !== 16 || FULL !== 1'b1 || PUSH_ACK !== 1'b1)
      $display("FAIL fill16 level=%0d full=%b ack=%b exp=16/1/1",
               LEVEL, FULL, PUSH_ACK);
    else n_pass++;
    step(0, 1, 33, 0);
    n_chk++;
    if (PUSH_ACK !== 1'b0 || OVF !== ERR_EN || LEVEL !== 16)
      $display("FAIL overflow ack=%b ovf=%b level=%0d exp=0/%b/16",
               PUSH_ACK, OVF, LEVEL, ERR_EN);
    else n_pass++;
  endtask

  task automatic test_drain();
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 0, 1);
      n_chk++;
      if (POP_ACK !== 1'b1 || POP_DAT !== 32 - i)
        $display("FAIL drain[%0d] ack=%b dat=%0d exp=1/%0d",
                 i, POP_ACK, POP_DAT, 32 - i);
      else n_pass++;
    end
    n_chk++;
    if (EMPTY !== 1'b1 || w_act !== model_vec())
      $display("FAIL drained act=%h exp=%h", w_act, model_vec());
    else n_pass++;
    step(0, 0, 0, 1);
    n_chk++;
    if (POP_ACK !== 1'b0 || UNF !== ERR_EN || POP_DAT !== 17)
      $display("FAIL underflow ack=%b unf=%b dat=%0d exp=0/%b/17",
               POP_ACK, UNF, POP_DAT, ERR_EN);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    step(1, 0, 0, 0);
    step(0, 1, 17, 0);
    step(0, 1, 18, 0);
    step(0, 1, 99, 1);
    n_chk++;
    if (POP_DAT !== 18 || LEVEL !== 2 || PUSH_ACK !== 1'b1 ||
        POP_ACK !== 1'b1)
      $display("FAIL swap dat=%0d level=%0d acks=%b%b exp=18/2/11",
               POP_DAT, LEVEL, PUSH_ACK, POP_ACK);
    else n_pass++;
    step(0, 0, 0, 1);
    n_chk++;
    if (POP_DAT !== 99 || POP_ACK !== 1'b1)
      $display("FAIL swap_pop1 dat=%0d exp=99", POP_DAT);
    else n_pass++;
    step(0, 0, 0, 1);
    n_chk++;
    if (POP_DAT !== 17 || EMPTY !== 1'b1)
      $display("FAIL swap_pop2 dat=%0d empty=%b exp=17/1", POP_DAT, EMPTY);
    else n_pass++;
  endtask

  task automatic test_boundaries();
    step(1, 0, 0, 0);
    step(0, 1, 32'h55, 1);
    n_chk++;
    if (PUSH_ACK !== 1'b1 || POP_ACK !== 1'b0 || LEVEL !== 1 ||
        UNF !== ERR_EN)
      $display("FAIL pp_empty acks=%b%b level=%0d unf=%b exp=10/1/%b",
               PUSH_ACK, POP_ACK, LEVEL, UNF, ERR_EN);
    else n_pass++;
    for (int i = 0; i < DEPTH - 1; i++) step(0, 1, 100 + i, 0);
    step(0, 1, 32'hAB, 1);
    n_chk++;
    if (PUSH_ACK !== 1'b1 || POP_ACK !== 1'b1 || LEVEL !== 16 ||
        POP_DAT !== 114)
      $display("FAIL pp_full acks=%b%b level=%0d dat=%0d exp=11/16/114",
               PUSH_ACK, POP_ACK, LEVEL, POP_DAT);
    else n_pass++;
    n_chk++;
    if (w_act !== model_vec())
      $display("FAIL pp_full_model act=%h exp=%h", w_act, model_vec());
    else n_pass++;
  endtask

  task automatic test_clear();
    step(1, 0, 0, 0);
    step(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 1, 200 + i, 0);
    n_chk++;
    if (LEVEL !== 5 || UNF !== ERR_EN)
      $display("FAIL pre_clear level=%0d unf=%b exp=5/%b", LEVEL, UNF, ERR_EN);
    else n_pass++;
    step(1, 1, 32'hDEAD, 0);
    n_chk++;
    if (LEVEL !== 0 || EMPTY !== 1'b1 || PUSH_ACK !== 1'b0 ||
        POP_ACK !== 1'b0 || OVF !== 1'b0 || UNF !== 1'b0)
      $display("FAIL clear level=%0d empty=%b acks=%b%b err=%b%b exp=0/1/00/00",
               LEVEL, EMPTY, PUSH_ACK, POP_ACK, OVF, UNF);
    else n_pass++;
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 2000; i++) begin
      int pw;
      bit c, ps, pp;
      pw = ((i / 150) % 2 == 0) ? 75 : 25;
      c  = ($urandom_range(63) == 0);
      ps = ($urandom_range(99) < pw);
      pp = ($urandom_range(99) < 100 - pw);
      step(c, ps, $urandom, pp);
      n_chk++;
      if (w_act !== model_vec()) begin
        if (bad < 10)
          $display("FAIL random[%0d] act=%h exp=%h", i, w_act, model_vec());
        bad++;
      end else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_simultaneous();
    test_boundaries();
    test_clear();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/lifo_stack.md
# lifo_stack

Parametrised LIFO stack with strobe/acknowledge push and pop ports, full/empty/level status, synchronous clear and defined simultaneous push+pop behaviour. It is the next generation of the team's fixed 32-bit stack and slots into the same datapaths as an operand or return-address buffer between a producer and a consumer in one clock domain. Storage is a register array indexed by a single stack pointer that doubles as the occupancy count.

## Interface
- WIDTH, 32, data word width in bits
- DEPTH, 16, number of entries (any value ≥ 2)
- CNT_W, 5, width of pointer/LEVEL; must satisfy 2^CNT_W > DEPTH
- CLK  input  1  clock, all logic on rising edge
- RST  input  1  asynchronous, active-low reset
- CLR  input  1  synchronous flush, empties the stack
- PUSH_STB  input  1  push request
- PUSH_DAT  input  WIDTH  data to push
- PUSH_ACK  output  1  one-cycle pulse: push accepted
- POP_STB  input  1  pop request
- POP_DAT  output  WIDTH  popped word, valid while POP_ACK=1
- POP_ACK  output  1  one-cycle pulse: pop accepted, POP_DAT valid
- FULL  output  1  LEVEL == DEPTH
- EMPTY  output  1  LEVEL == 0
- LEVEL  output  CNT_W  current number of stored entries
- OVF  output  1  sticky push-while-full error (see Configuration)
- UNF  output  1  sticky pop-while-empty error (see Configuration)

## Operation
- Pointer SP = LEVEL; top of stack is mem[SP-1]. No FSM; state is SP plus registered ACK/data outputs.
- Reset (RST=0, asynchronous): SP=0, PUSH_ACK=0, POP_ACK=0, POP_DAT=0, OVF=0, UNF=0; EMPTY=1, FULL=0, LEVEL=0. Array contents not reset. Reset mid-burst drops all in-flight requests; no ACK issued.
- Priority per edge: CLR > push/pop. CLR=1: SP←0, no ACK, requests that cycle ignored, OVF/UNF cleared.
- Push only (PUSH_STB=1, POP_STB=0): accepted iff !FULL; mem[SP]←PUSH_DAT, SP←SP+1, PUSH_ACK=1 next cycle. If FULL: dropped, no ACK, no state change.
- Pop only: accepted iff !EMPTY; POP_DAT←mem[SP-1], SP←SP-1, POP_ACK=1 next cycle. If EMPTY: no ACK, POP_DAT holds previous value.
- Push+pop, stack not empty (including FULL): both accepted; POP_DAT←mem[SP-1] (old top), mem[SP-1]←PUSH_DAT, SP unchanged; PUSH_ACK=POP_ACK=1.
- Push+pop, stack EMPTY: push accepted alone, pop rejected (no bypass of PUSH_DAT to POP_DAT).
- Strobes are level requests: holding a strobe high issues one request per cycle.
- POP_DAT holds its value until the next accepted pop; consumers sample it with POP_ACK.
- SP never wraps: bounded to 0..DEPTH by the acceptance rules.

## Timing
- Accept decision uses FULL/EMPTY at the sampling edge; ACKs appear one cycle after request edge.
- FULL, EMPTY, LEVEL reflect SP after the edge (registered-pointer decode, no input-to-output path).
- Sustained throughput: one push or pop or push+pop per cycle.
- Pop after push of same word: push at edge n, pop request at edge n+1, POP_DAT/POP_ACK valid after edge n+1.

## Configuration
- Macro LIFO_STACK_ERR_EN.
- Defined: OVF set on a push rejected due to FULL (no simultaneous pop); UNF set on a pop rejected due to EMPTY (including push+pop on empty). Both sticky until CLR or reset.
- Not defined: OVF and UNF ports remain, tied to constant 0; no error registers synthesised.

## Test plan
- Reset: RST low 400 ns mid-run -> all outputs at reset values, EMPTY=1, LEVEL=0; release, no spurious ACK.
- Fill: DEPTH=16, push 17..31 back-to-back -> 15 PUSH_ACK pulses, LEVEL=15, FULL=0; push 32 -> LEVEL=16, FULL=1; push 33 -> no ACK, OVF=1 (macro on) / 0 (off).
- Drain: continuous POP_STB on full stack -> POP_DAT 32,31,...,17 on 16 consecutive POP_ACK pulses, then EMPTY=1, further pops give no ACK, UNF=1 with macro.
- Simultaneous: stack holds 17,18; push 99 with pop -> POP_DAT=18, LEVEL stays 2; next pop -> 99, then 17.
- Boundaries: push+pop on EMPTY -> PUSH_ACK only, LEVEL=1, no POP_ACK; push+pop on FULL -> both ACK, LEVEL=16.
- Clear: LEVEL=5, assert CLR with PUSH_STB=1 -> next cycle LEVEL=0, EMPTY=1, no ACK, OVF/UNF=0.
